// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing control: load-use stalls, branch flushes
// and multi-cycle mult/div stalls for the 5-stage core.
module hazard_stall_ctrl #(
    parameter int MD_CYCLES = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IDrs,
    input  logic [4:0]       IDrt,
    input  logic             IDUsesRt,
    input  logic             IDEXMemRead,
    input  logic [4:0]       IDEXrt,
    input  logic             BranchTaken,
    input  logic             MDStart,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDHold,
    output logic             IDEXBubble,
    output logic             MDBusy,
    output logic [CNT_W-1:0] StallCount
);

    localparam int MDW = $clog2(MD_CYCLES);
    localparam logic [MDW-1:0] MD_LOAD = MDW'(MD_CYCLES - 1);

    typedef enum logic {
        RUN,
        MD_BUSY
    } state_t;

    state_t         state, state_nxt;
    logic [MDW-1:0] md_cnt, md_cnt_nxt;
    logic           load_use;

    assign load_use = IDEXMemRead && (IDEXrt != 5'd0) &&
                      ((IDEXrt == IDrs) ||
                       (IDUsesRt && (IDEXrt == IDrt)));

    always_comb begin
        state_nxt  = state;
        md_cnt_nxt = md_cnt;
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IFIDHold   = 1'b0;
        IDEXBubble = 1'b0;
        MDBusy     = 1'b0;
        // Outputs follow reset asynchronously, not just the registers
        if (!rst_n) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
            state_nxt  = RUN;
            md_cnt_nxt = '0;
        end else begin
            unique case (state)
                MD_BUSY: begin
                    PCWrite    = 1'b0;
                    IFIDHold   = 1'b1;
                    IDEXBubble = 1'b1;
                    MDBusy     = 1'b1;
                    md_cnt_nxt = md_cnt - MDW'(1);
                    if (md_cnt == MDW'(1))
                        state_nxt = RUN;
                end
                RUN: begin
                    if (load_use) begin
                        PCWrite    = 1'b0;
                        IFIDHold   = 1'b1;
                        IDEXBubble = 1'b1;
                    end else if (BranchTaken) begin
                        IFIDWrite = 1'b0;
                    end else if (MDStart) begin
                        state_nxt  = MD_BUSY;
                        md_cnt_nxt = MD_LOAD;
                    end
                end
                default: begin
                    state_nxt  = RUN;
                    md_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            StallCount <= '0;
        else if (!PCWrite && (StallCount != '1))
            StallCount <= StallCount + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl (MD_CYCLES=4, CNT_W=4).
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] IDrs, IDrt, IDEXrt;
    logic       IDUsesRt, IDEXMemRead, BranchTaken, MDStart;
    logic       PCWrite, IFIDWrite, IFIDHold, IDEXBubble, MDBusy;
    logic [3:0] StallCount;

    int vecs = 0;
    int miscmp = 0;

    localparam logic [4:0] O_RST  = 5'b00010;
    localparam logic [4:0] O_RUN  = 5'b11000;
    localparam logic [4:0] O_LU   = 5'b01110;
    localparam logic [4:0] O_BR   = 5'b10000;
    localparam logic [4:0] O_BUSY = 5'b01111;

    hazard_stall_ctrl #(.MD_CYCLES(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .IDrs(IDrs), .IDrt(IDrt), .IDUsesRt(IDUsesRt),
        .IDEXMemRead(IDEXMemRead), .IDEXrt(IDEXrt),
        .BranchTaken(BranchTaken), .MDStart(MDStart),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .IFIDHold(IFIDHold), .IDEXBubble(IDEXBubble),
        .MDBusy(MDBusy), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscmp++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [4:0] exp);
        #1;
        chk(tag, {11'd0, PCWrite, IFIDWrite, IFIDHold,
                  IDEXBubble, MDBusy}, {11'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        IDrs = 0; IDrt = 0; IDEXrt = 0; IDUsesRt = 0;
        IDEXMemRead = 0; BranchTaken = 0; MDStart = 0;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #2;
        chk_out("reset_outs", O_RST);
        chk("reset_cnt", 16'(StallCount), 16'd0);
        tick();
        tick();
        chk_out("reset_held", O_RST);

        rst_n = 1'b1;
        chk_out("run_idle", O_RUN);
        tick();
        chk("run_cnt", 16'(StallCount), 16'd0);

        // load-use on rs
        IDEXMemRead = 1; IDEXrt = 8; IDrs = 8;
        chk_out("lu_rs", O_LU);
        tick();
        idle();
        chk_out("lu_clear", O_RUN);
        chk("lu_cnt", 16'(StallCount), 16'd1);

        // $zero never hazards
        IDEXMemRead = 1; IDEXrt = 0; IDrs = 0;
        chk_out("lu_r0", O_RUN);
        tick();
        chk("lu_r0_cnt", 16'(StallCount), 16'd1);

        // rt match ignored unless rt is read
        IDEXMemRead = 1; IDEXrt = 9; IDrt = 9; IDrs = 3; IDUsesRt = 0;
        chk_out("lu_rt_unused", O_RUN);
        IDUsesRt = 1;
        chk_out("lu_rt_used", O_LU);
        tick();
        idle();
        chk("lu_rt_cnt", 16'(StallCount), 16'd2);

        // taken branch flush
        BranchTaken = 1;
        chk_out("br_flush", O_BR);
        tick();
        chk("br_cnt", 16'(StallCount), 16'd2);

        // branch with load-use: stall only
        IDEXMemRead = 1; IDEXrt = 8; IDrs = 8;
        chk_out("br_lu", O_LU);
        tick();
        IDEXMemRead = 0;
        chk_out("br_reeval", O_BR);
        chk("br_lu_cnt", 16'(StallCount), 16'd3);
        idle();

        // mult/div: issue, then 3 busy cycles
        MDStart = 1;
        chk_out("md_issue", O_RUN);
        tick();
        idle();
        chk_out("md_busy1", O_BUSY);
        BranchTaken = 1;
        MDStart = 1;
        chk_out("md_busy1_ign", O_BUSY);
        tick();
        chk_out("md_busy2", O_BUSY);
        tick();
        chk_out("md_busy3", O_BUSY);
        idle();
        tick();
        chk_out("md_done", O_RUN);
        chk("md_cnt", 16'(StallCount), 16'd6);

        // load-use defers MDStart
        MDStart = 1; IDEXMemRead = 1; IDEXrt = 5; IDrs = 5;
        chk_out("md_lu", O_LU);
        tick();
        IDEXMemRead = 0;
        chk_out("md_lu_issue", O_RUN);
        tick();
        idle();
        chk_out("md_lu_busy", O_BUSY);
        tick();
        tick();
        tick();
        chk_out("md_lu_done", O_RUN);
        chk("md_lu_cnt", 16'(StallCount), 16'd10);

        // reset during second busy cycle
        MDStart = 1;
        tick();
        idle();
        tick();
        chk_out("md_rst_pre", O_BUSY);
        rst_n = 1'b0;
        chk_out("md_rst_outs", O_RST);
        chk("md_rst_cnt", 16'(StallCount), 16'd0);
        tick();
        rst_n = 1'b1;
        chk_out("md_rst_rel", O_RUN);
        tick();
        chk_out("md_rst_run", O_RUN);
        chk("md_rst_cnt2", 16'(StallCount), 16'd0);

        // saturation
        IDEXMemRead = 1; IDEXrt = 7; IDrs = 7;
        for (int i = 0; i < 14; i++) tick();
        chk("sat_14", 16'(StallCount), 16'd14);
        tick();
        chk("sat_15", 16'(StallCount), 16'd15);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_hold", 16'(StallCount), 16'd15);
        idle();
        chk_out("sat_run", O_RUN);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, miscmp);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Drives the PC write-enable, the IF/ID write/flush controls and the ID/EX bubble insert.
- Resolves load-use hazards, taken-branch flushes in ID and multi-cycle mult/div stalls.
- Sits beside the IF/ID register and consumes its decoded rs/rt/opcode fields plus ID/EX state.

Parameters:
- MD_CYCLES, 4, total cycles a mult/div occupies EX (>=2).
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- IDrs  in  5  rs field of the instruction in ID.
- IDrt  in  5  rt field of the instruction in ID.
- IDUsesRt  in  1  instruction in ID reads rt (R-type, beq/bne, sw).
- IDEXMemRead  in  1  instruction in EX is a load.
- IDEXrt  in  5  destination rt of the instruction in EX.
- BranchTaken  in  1  branch in ID resolved taken this cycle.
- MDStart  in  1  instruction in ID is mult/div and will issue.
- PCWrite  out  1  1 = PC loads next address.
- IFIDWrite  out  1  1 = IF/ID loads; 0 = IF/ID clears to NOP.
- IFIDHold  out  1  1 = IF/ID keeps its contents (overrides IFIDWrite).
- IDEXBubble  out  1  1 = ID/EX loads zeros (NOP).
- MDBusy  out  1  mult/div sequence in progress.
- StallCount  out  CNT_W  saturating count of stall cycles since reset.

Behaviour:
- States: RUN, MD_BUSY. State, remaining-cycle counter and StallCount are registers. All other outputs are combinational from state and inputs.
- Reset (rst_n=0, async):
  - state=RUN, md counter=0, StallCount=0.
  - PCWrite=0, IFIDWrite=0, IFIDHold=0, IDEXBubble=1, MDBusy=0.
  - Reset asserted mid MD_BUSY aborts the sequence immediately.
- RUN, no event: PCWrite=1, IFIDWrite=1, IFIDHold=0, IDEXBubble=0.
- Load-use condition: IDEXMemRead=1 and IDEXrt!=0 and (IDEXrt==IDrs or (IDUsesRt and IDEXrt==IDrt)).
  - Same cycle: PCWrite=0, IFIDHold=1, IDEXBubble=1.
  - Exactly 1 stall cycle per load, because the next cycle the load has moved out of EX.
- Taken branch (RUN, no load-use): PCWrite=1, IFIDWrite=0 for one cycle. The wrong-path fetch is zeroed and IDEXBubble=0.
- MDStart in RUN (no load-use):
  - Instruction issues this cycle with normal outputs.
  - Next edge: state=MD_BUSY, counter=MD_CYCLES-1.
- MD_BUSY:
  - PCWrite=0, IFIDHold=1, IDEXBubble=1, MDBusy=1.
  - Counter decrements each edge. When counter==1, next state=RUN.
  - Stall length is exactly MD_CYCLES-1 cycles.
  - BranchTaken and MDStart are ignored while in MD_BUSY.
- Priority, highest first: reset > MD_BUSY > load-use > BranchTaken > MDStart.
  - Load-use with BranchTaken: stall only, no flush; the branch re-evaluates next cycle.
  - Load-use with MDStart: stall; MDStart is accepted when the hazard clears.
- StallCount:
  - +1 on each edge where PCWrite=0 and rst_n=1.
  - Saturates at 2^CNT_W-1 and never wraps.
- No X on any output after reset release. All outputs must be valid in the first cycle after reset release.

Test Plan:
- Reset, then release with all inputs 0 -> PCWrite=1, IFIDWrite=1, IDEXBubble=0, StallCount=0.
- IDEXMemRead=1, IDEXrt=8, IDrs=8 for one cycle, then IDEXMemRead=0 -> exactly one cycle of PCWrite=0/IFIDHold=1/IDEXBubble=1; StallCount=1.
- Load-use with IDEXrt=0 = IDrs, and separately IDEXrt=9, IDrt=9, IDUsesRt=0 -> no stall in either case.
- BranchTaken=1 for one cycle -> IFIDWrite=0 for that cycle, PCWrite=1, StallCount unchanged. Repeat with a simultaneous load-use -> stall only, IFIDWrite=1.
- MDStart pulse with MD_CYCLES=4 -> MDBusy=1 for exactly 3 cycles starting the next cycle; BranchTaken inside the window is ignored; StallCount=3.
- rst_n low during the second MD_BUSY cycle -> immediate RUN reset outputs. After release, no residual stall and StallCount=0.
- Force 2^CNT_W stall cycles (CNT_W=4) -> StallCount holds at 15.
